sum_accumulator: RTL and testbench
==================================

// Module: sum_accumulator
// PURPOSE
//  Downstream consumer of the 32-bit ripple adder stage. Takes each {carry,sum} result over a valid/ready
//  handshake and accumulates COUNT consecutive results into a wide register.
//  Presents the frame total, with a sticky overflow flag, on a second valid/ready output.
//  Feeds the display/readout logic.
// PARAMETERS
//  DATA_W  32  width of adder sum input
//  ACC_W   40  accumulator/result width; must be >= DATA_W+1
//  COUNT   4   adder results per frame; must be >= 1
// PORTS
//  clk        in   1           rising-edge clock, single clock domain
//  rst_n      in   1           synchronous active-low reset
//  in_valid   in   1           adder result present
//  in_ready   out  1           block accepts a result this cycle
//  in_sum     in   DATA_W      adder sum
//  in_carry   in   1           adder carry-out
//  clear      in   1           synchronous abort of the current frame
//  out_valid  out  1           frame result present
//  out_ready  in   1           consumer takes the result
//  out_acc    out  ACC_W       frame total, mod 2^ACC_W
//  out_ovf    out  1           frame total wrapped past 2^ACC_W
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): state=ACC, acc=0, cnt=0, ovf_acc=0, out_valid=0, out_acc=0, out_ovf=0.
//  - in_ready is 0 while rst_n=0.
//  - Operand = {in_carry,in_sum} zero-extended to ACC_W, i.e. DATA_W+1 significant bits.
//  - States:
//    - ACC: in_ready=1. Accept when in_valid&&in_ready.
//    - HOLD: in_ready=0, out_valid=1.
//  - Accept in ACC:
//    - {c,acc} <= acc+operand. Result wraps mod 2^ACC_W; ovf_acc |= c.
//    - cnt <= cnt+1.
//  - Frame end: an accept with cnt==COUNT-1 does all of the following on that edge:
//    - out_acc <= acc+operand (wrapped);
//    - out_ovf <= ovf_acc|c;
//    - acc, cnt and ovf_acc <= 0;
//    - out_valid <= 1; state -> HOLD.
//  - Latency: out_valid rises 1 cycle after the COUNT-th accepting edge.
//  - HOLD:
//    - out_acc and out_ovf stay stable until out_valid&&out_ready.
//    - On that handshake: out_valid <= 0, state -> ACC.
//    - in_ready returns the following cycle, giving a 1-cycle bubble.
//  - in_valid=0 in ACC: nothing changes. Gaps between accepts are allowed and unlimited.
//  - clear=1 (rst_n=1): acc, cnt and ovf_acc <= 0; out_valid <= 0; state -> ACC.
//    - Any pending result is discarded; out_acc and out_ovf keep their last values.
//    - clear beats a same-cycle accept or handshake; that input is not counted.
//  - rst_n beats clear. Reset mid-frame or in HOLD discards everything.
//  - COUNT=1: every accept is a frame end, going straight to HOLD.
// TESTING
//  1. Reset, then 4 accepts:
//     - inputs (sum,carry) = (1100,0), (1100,0), (13100,1), (110020,0);
//     - required: out_valid=1 one cycle after the 4th accept, out_acc=2^32+125320, out_ovf=0;
//     - then out_ready=1 gives out_valid=0 and in_ready=1 on the next cycle.
//  2. Hold out_ready=0 for 10 cycles after a frame:
//     - out_acc and out_ovf stay stable, in_ready=0;
//     - in_valid pulses in HOLD are not counted; the next frame total is independent of them.
//  3. ACC_W=34, 4 accepts of in_sum=32'hFFFFFFFF, in_carry=1:
//     - out_acc=34'h3_FFFF_FFFC, out_ovf=1;
//     - the next frame of 4 zeros gives out_acc=0, out_ovf=0.
//  4. Clear mid-frame:
//     - 2 accepts of 500, then clear=1 together with in_valid=1 (sum 999);
//     - then 4 accepts of 600 give out_acc=2400; the 500s and 999 do not appear.
//  5. rst_n=0 for 1 cycle while in HOLD:
//     - required: out_valid=0, out_acc=0, out_ovf=0, state ACC;
//     - in_ready=1 once rst_n=1.
//  6. Back-to-back throughput:
//     - in_valid held high, out_ready held high;
//     - one frame completes every COUNT+1 cycles, with no lost or duplicated operands.

Source files
------------

// File: rtl/sum_accumulator.sv
// Accumulates COUNT consecutive {carry,sum} adder results into a wide total and
// presents each frame total, with a sticky overflow flag, over a valid/ready output.
module sum_accumulator #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 40,
  parameter int COUNT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              in_carry,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;

  localparam logic [0:0] S_ACC  = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf_acc;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_acc;
  logic             r_out_ovf;

  logic [ACC_W-1:0] w_operand;
  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic             w_accept;
  logic             w_last;

  // Carry bit becomes bit DATA_W of the operand; the extra top bit of w_sum is the wrap.
  assign w_operand = ACC_W'({in_carry, in_sum});
  assign w_sum     = {1'b0, r_acc} + {1'b0, w_operand};
  assign w_carry   = w_sum[ACC_W];

  assign in_ready  = rst_n && (r_state == S_ACC);
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_cnt == CNT_W'(COUNT - 1));

  assign out_valid = r_out_valid;
  assign out_acc   = r_out_acc;
  assign out_ovf   = r_out_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_ACC;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf_acc   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_ovf   <= 1'b0;
    end else if (clear) begin
      // Abort drops the running frame and any pending result, but the last
      // published total stays visible on out_acc/out_ovf.
      r_state     <= S_ACC;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf_acc   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_ACC: begin
          if (w_accept) begin
            if (w_last) begin
              r_out_acc   <= w_sum[ACC_W-1:0];
              r_out_ovf   <= r_ovf_acc | w_carry;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_ovf_acc   <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= S_HOLD;
            end else begin
              r_acc     <= w_sum[ACC_W-1:0];
              r_cnt     <= r_cnt + 1'b1;
              r_ovf_acc <= r_ovf_acc | w_carry;
            end
          end
        end
        S_HOLD: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_ACC;
          end
        end
        default: r_state <= S_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator: directed frames push expected totals,
// monitors pop and compare on every output handshake of a 40-bit and a 34-bit instance.
module tb_sum_accumulator;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_carry, clear, out_ready;
  logic [31:0] in_sum;
  logic        in_ready, out_valid, out_ovf;
  logic [39:0] out_acc;

  logic        b_in_valid, b_in_carry, b_clear, b_out_ready;
  logic [31:0] b_in_sum;
  logic        b_in_ready, b_out_valid, b_out_ovf;
  logic [33:0] b_out_acc;

  int checks = 0;
  int errors = 0;
  int stallCount = 0;

  logic [40:0] expQ[$];
  logic [34:0] expQ34[$];

  sum_accumulator #(.DATA_W(32), .ACC_W(40), .COUNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf)
  );

  sum_accumulator #(.DATA_W(32), .ACC_W(34), .COUNT(4)) dut34 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_sum(b_in_sum), .in_carry(b_in_carry), .clear(b_clear), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_acc(b_out_acc), .out_ovf(b_out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Monitors compare each handshaken frame result against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result actual=%0h required=none", out_acc);
      end else begin
        logic [40:0] e;
        e = expQ.pop_front();
        checkOutput("out_acc", 64'(out_acc), 64'(e[39:0]));
        checkOutput("out_ovf", 64'(out_ovf), 64'(e[40]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_out_valid && b_out_ready) begin
      if (expQ34.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result34 actual=%0h required=none", b_out_acc);
      end else begin
        logic [34:0] e;
        e = expQ34.pop_front();
        checkOutput("out_acc34", 64'(b_out_acc), 64'(e[33:0]));
        checkOutput("out_ovf34", 64'(b_out_ovf), 64'(e[34]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand and holds it until accepted; leaves in_valid high.
  task automatic applyStimulus(input bit sel, input logic [31:0] sum, input logic carry);
    int waits;
    logic rdy;
    if (sel) begin
      b_in_valid = 1'b1; b_in_sum = sum; b_in_carry = carry;
    end else begin
      in_valid = 1'b1; in_sum = sum; in_carry = carry;
    end
    waits = 0;
    forever begin
      @(negedge clk);
      rdy = sel ? b_in_ready : in_ready;
      cyc();
      if (rdy) break;
      waits++;
      stallCount++;
      if (waits > 50) begin
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout actual=%0d required<=50", waits);
        break;
      end
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    b_in_valid = 1'b0;
    cyc();
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; in_carry = 1'b0; clear = 1'b0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_sum = '0; b_in_carry = 1'b0; b_clear = 1'b0; b_out_ready = 1'b1;

    // Test 1: reset state, then a four-operand frame with a carry.
    cyc();
    cyc();
    @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_acc", 64'(out_acc), 64'd0);
    checkOutput("rst_out_ovf", 64'(out_ovf), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);
    cyc();
    expQ.push_back({1'b0, 40'd4295092616});
    applyStimulus(0, 32'd1100, 1'b0);
    applyStimulus(0, 32'd1100, 1'b0);
    applyStimulus(0, 32'd13100, 1'b1);
    applyStimulus(0, 32'd110020, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("t1_latency_valid", 64'(out_valid), 64'd1);
    checkOutput("t1_hold_in_ready", 64'(in_ready), 64'd0);
    cyc();
    @(negedge clk);
    checkOutput("t1_after_hs_valid", 64'(out_valid), 64'd0);
    checkOutput("t1_after_hs_in_ready", 64'(in_ready), 64'd1);
    cyc();

    // Test 2: long hold with ignored in_valid pulses, then an independent frame.
    out_ready = 1'b0;
    applyStimulus(0, 32'd10, 1'b0);
    applyStimulus(0, 32'd20, 1'b0);
    applyStimulus(0, 32'd30, 1'b0);
    applyStimulus(0, 32'd40, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2) == 0;
      in_sum = 32'd7777;
      in_carry = 1'b1;
      @(negedge clk);
      checkOutput("t2_hold_valid", 64'(out_valid), 64'd1);
      checkOutput("t2_hold_acc", 64'(out_acc), 64'd100);
      checkOutput("t2_hold_ovf", 64'(out_ovf), 64'd0);
      checkOutput("t2_hold_in_ready", 64'(in_ready), 64'd0);
      cyc();
    end
    in_valid = 1'b0;
    expQ.push_back({1'b0, 40'd100});
    out_ready = 1'b1;
    cyc();
    expQ.push_back({1'b0, 40'd10});
    applyStimulus(0, 32'd1, 1'b0);
    applyStimulus(0, 32'd2, 1'b0);
    applyStimulus(0, 32'd3, 1'b0);
    applyStimulus(0, 32'd4, 1'b0);
    drain();

    // Test 3: wrap past 2^34 on the narrow instance, then an all-zero frame.
    expQ34.push_back({1'b1, 34'h3_FFFF_FFFC});
    expQ34.push_back({1'b0, 34'h0});
    for (int i = 0; i < 4; i++) applyStimulus(1, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 32'h0, 1'b0);
    drain();

    // Test 4: clear mid-frame beats a same-cycle input.
    applyStimulus(0, 32'd500, 1'b0);
    applyStimulus(0, 32'd500, 1'b0);
    in_valid = 1'b1; in_sum = 32'd999; in_carry = 1'b0; clear = 1'b1;
    cyc();
    clear = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("t4_clear_in_ready", 64'(in_ready), 64'd1);
    checkOutput("t4_clear_valid", 64'(out_valid), 64'd0);
    checkOutput("t4_clear_keeps_acc", 64'(out_acc), 64'd10);
    cyc();
    expQ.push_back({1'b0, 40'd2400});
    for (int i = 0; i < 4; i++) applyStimulus(0, 32'd600, 1'b0);
    drain();

    // Test 5: reset while holding a result discards it.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(0, 32'd5, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("t5_hold_valid", 64'(out_valid), 64'd1);
    checkOutput("t5_hold_ovf", 64'(out_ovf), 64'd0);
    cyc();
    rst_n = 1'b0;
    cyc();
    checkOutput("t5_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("t5_rst_acc", 64'(out_acc), 64'd0);
    checkOutput("t5_rst_ovf", 64'(out_ovf), 64'd0);
    checkOutput("t5_rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t5_post_rst_in_ready", 64'(in_ready), 64'd1);
    cyc();

    // Test 6: back-to-back frames, one bubble cycle per frame.
    out_ready = 1'b1;
    stallCount = 0;
    expQ.push_back({1'b0, 40'd10});
    expQ.push_back({1'b0, 40'd26});
    expQ.push_back({1'b0, 40'd42});
    for (int i = 1; i <= 12; i++) applyStimulus(0, 32'(i), 1'b0);
    checkOutput("t6_bubbles", 64'(stallCount), 64'd2);
    drain();
    cyc();
    cyc();

    checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
    checkOutput("scoreboard34_empty", 64'(expQ34.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
